// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: state encoding,
// requester IDs and default bus widths.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // State records which requester won the previous cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request/command in,
// combinational grant plus registered read return out.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input arbitration decision: a lone requester wins; on a tie the dma
// keeps the port while its burst is allowed, otherwise the non-last winner wins.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       lock_ok,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = req;
    if (req[REQ_CPU] && req[REQ_DMA]) begin
      gnt_c = 2'b00;
      if (lock_ok || (last_winner == REQ_CPU)) begin
        gnt_c[REQ_DMA] = 1'b1;
      end else begin
        gnt_c[REQ_CPU] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the MEM stage (cpu) and a DMA
// port: one grant per cycle, range-checked memory drive, 1-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dma,
  input  logic              dma_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              addr_err
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e       state, state_nxt;
  logic             last_winner, last_winner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic [1:0]        req_vec;
  logic [1:0]        pick;
  logic              lock_ok;
  logic              cpu_win, dma_win;
  logic              win_we, win_in_range;
  logic [ADDR_W-1:0] win_addr;

  assign req_vec[REQ_CPU] = cpu.req;
  assign req_vec[REQ_DMA] = dma.req;

  assign lock_ok = (state == DMA_ACC) && dma_lock && (burst_cnt < CNT_W'(BURST_MAX));

  rr_pick2 u_pick (
    .req         (req_vec),
    .last_winner (last_winner),
    .lock_ok     (lock_ok),
    .gnt_c       (pick)
  );

  assign cpu_win = pick[REQ_CPU] & ~reset;
  assign dma_win = pick[REQ_DMA] & ~reset;
  assign cpu.gnt = cpu_win;
  assign dma.gnt = dma_win;

  // With no winner the memory bus idles on the cpu inputs.
  assign win_addr     = dma_win ? dma.addr : cpu.addr;
  assign win_we       = (cpu_win & cpu.we) | (dma_win & dma.we);
  assign win_in_range = (win_addr < ADDR_W'(DEPTH));
  assign mem_addr     = win_addr;
  assign mem_wd       = dma_win ? dma.wdata : cpu.wdata;
  assign mem_we       = win_we & win_in_range & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_winner <= REQ_DMA;
      burst_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
      burst_cnt   <= burst_cnt_nxt;
    end
  end

  // Burst count tracks dma grants taken while the cpu is waiting.
  always_comb begin
    state_nxt       = IDLE;
    last_winner_nxt = last_winner;
    burst_cnt_nxt   = burst_cnt;
    if (cpu_win) begin
      state_nxt       = CPU_ACC;
      last_winner_nxt = REQ_CPU;
    end else if (dma_win) begin
      state_nxt       = DMA_ACC;
      last_winner_nxt = REQ_DMA;
    end
    if (!cpu.req || cpu_win) begin
      burst_cnt_nxt = '0;
    end else if (dma_win && (burst_cnt < CNT_W'(BURST_MAX))) begin
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu.rvalid <= 1'b0;
      dma.rvalid <= 1'b0;
      cpu.rdata  <= '0;
      dma.rdata  <= '0;
      addr_err   <= 1'b0;
    end else begin
      cpu.rvalid <= cpu_win & ~cpu.we;
      dma.rvalid <= dma_win & ~dma.we;
      addr_err   <= (cpu_win | dma_win) & ~win_in_range;
      if (cpu_win && !cpu.we) begin
        cpu.rdata <= win_in_range ? mem_rd : '0;
      end
      if (dma_win && !dma.we) begin
        dma.rdata <= win_in_range ? mem_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, each cycle
// checked against a rule-level model of grants, read returns and memory.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 32;
  localparam int          DEPTH     = 8;
  localparam int          BURST_MAX = 4;
  localparam int unsigned IW        = 3;

  logic clk = 1'b0;
  logic reset;
  logic dma_lock;
  logic env_init;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic mem_we, addr_err;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) cpu_bus ();
  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) dma_bus ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (cpu_bus),
    .dma      (dma_bus),
    .dma_lock (dma_lock),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .addr_err (addr_err)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return (i == 3) ? 32'h0000_00AA : (32'h5A00_0000 + 32'(i));
  endfunction

  // Environment memory; reads beyond DEPTH return junk the arbiter must mask.
  logic [DW-1:0] mem_array [DEPTH];
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < DEPTH; i++) mem_array[i] <= init_word(i);
    end else if (mem_we) begin
      mem_array[mem_addr[IW-1:0]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_addr < AW'(DEPTH)) ? mem_array[mem_addr[IW-1:0]] : 32'hDEAD_BEEF;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who won last cycle (0 none, 1 cpu, 2 dma), last real
  // winner, dma grants in a row while cpu waits, and the expected memory.
  logic [DW-1:0] ref_mem [DEPTH];
  int m_prev, m_last, m_run;
  logic exp_cpu_rv, exp_dma_rv, exp_err;
  logic [DW-1:0] exp_cpu_rd, exp_dma_rd;
  logic got_cpu_gnt, got_dma_gnt, got_mem_we;

  function automatic int model_winner();
    if (reset) return 0;
    if (cpu_bus.req && !dma_bus.req) return 1;
    if (dma_bus.req && !cpu_bus.req) return 2;
    if (!cpu_bus.req && !dma_bus.req) return 0;
    if (m_prev == 2 && dma_lock && m_run < BURST_MAX) return 2;
    return (m_last == 2) ? 1 : 2;
  endfunction

  task automatic model_commit(int w);
    logic [AW-1:0] a;
    logic we;
    logic [DW-1:0] d;
    bit inr;
    if (reset) begin
      exp_cpu_rv = 0; exp_dma_rv = 0; exp_err = 0;
      exp_cpu_rd = '0; exp_dma_rd = '0;
      m_prev = 0; m_last = 2; m_run = 0;
      if (env_init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      return;
    end
    a   = (w == 2) ? dma_bus.addr  : cpu_bus.addr;
    we  = (w == 2) ? dma_bus.we    : cpu_bus.we;
    d   = (w == 2) ? dma_bus.wdata : cpu_bus.wdata;
    inr = (a < AW'(DEPTH));
    exp_cpu_rv = (w == 1) && !we;
    exp_dma_rv = (w == 2) && !we;
    exp_err    = (w != 0) && !inr;
    if (exp_cpu_rv) exp_cpu_rd = inr ? ref_mem[a[IW-1:0]] : '0;
    if (exp_dma_rv) exp_dma_rd = inr ? ref_mem[a[IW-1:0]] : '0;
    if (w != 0 && we && inr) ref_mem[a[IW-1:0]] = d;
    if (!cpu_bus.req || w == 1) m_run = 0;
    else if (w == 2 && m_run < BURST_MAX) m_run++;
    m_prev = w;
    if (w != 0) m_last = w;
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic step(string tag);
    int w;
    logic exp_we;
    logic [AW-1:0] exp_addr;
    #1;
    w = model_winner();
    got_cpu_gnt = cpu_bus.gnt;
    got_dma_gnt = dma_bus.gnt;
    got_mem_we  = mem_we;
    exp_addr = (w == 2) ? dma_bus.addr : cpu_bus.addr;
    exp_we = (w == 1) ? cpu_bus.we : (w == 2) ? dma_bus.we : 1'b0;
    exp_we = exp_we && (exp_addr < AW'(DEPTH));
    check({tag, "_cpu_gnt"}, 32'(cpu_bus.gnt), 32'(w == 1));
    check({tag, "_dma_gnt"}, 32'(dma_bus.gnt), 32'(w == 2));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
    if (w != 0) check({tag, "_mem_addr"}, mem_addr, exp_addr);
    @(posedge clk);
    model_commit(w);
    #1;
    check({tag, "_cpu_rvalid"}, 32'(cpu_bus.rvalid), 32'(exp_cpu_rv));
    check({tag, "_dma_rvalid"}, 32'(dma_bus.rvalid), 32'(exp_dma_rv));
    check({tag, "_cpu_rdata"}, cpu_bus.rdata, exp_cpu_rd);
    check({tag, "_dma_rdata"}, dma_bus.rdata, exp_dma_rd);
    check({tag, "_addr_err"}, 32'(addr_err), 32'(exp_err));
    @(negedge clk);
  endtask

  task automatic set_cpu(bit req, bit we, int addr, logic [DW-1:0] d);
    cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = AW'(addr); cpu_bus.wdata = d;
  endtask

  task automatic set_dma(bit req, bit we, int addr, logic [DW-1:0] d);
    dma_bus.req = req; dma_bus.we = we; dma_bus.addr = AW'(addr); dma_bus.wdata = d;
  endtask

  task automatic do_reset();
    set_cpu(0, 0, 0, '0); set_dma(0, 0, 0, '0); dma_lock = 0;
    reset = 1; step("rst");
    reset = 0;
  endtask

  int pat [7] = '{2, 2, 2, 2, 1, 2, 1};

  initial begin
    m_prev = 0; m_last = 2; m_run = 0;
    reset = 1; env_init = 1; dma_lock = 0;
    set_cpu(0, 0, 0, '0); set_dma(0, 0, 0, '0);
    @(negedge clk);
    step("init");
    env_init = 0;
    step("rst0");
    check("rst_cpu_rdata", cpu_bus.rdata, 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    reset = 0;

    // Single cpu read of word 3
    set_cpu(1, 0, 3, '0);
    step("t1");
    check("t1_gnt", 32'(got_cpu_gnt), 32'h1);
    check("t1_rvalid", 32'(cpu_bus.rvalid), 32'h1);
    check("t1_rdata", cpu_bus.rdata, 32'h0000_00AA);
    check("t1_dma_rvalid", 32'(dma_bus.rvalid), 32'h0);
    set_cpu(0, 0, 0, '0);

    // Tie after reset: cpu first, then dma write, then cpu reads it back
    do_reset();
    set_cpu(1, 0, 1, '0); set_dma(1, 1, 2, 32'h1234);
    step("t2c0");
    check("t2_c0_cpu", 32'(got_cpu_gnt), 32'h1);
    step("t2c1");
    check("t2_c1_dma", 32'(got_dma_gnt), 32'h1);
    set_cpu(1, 0, 2, '0); set_dma(0, 0, 0, '0);
    step("t2c2");
    check("t2_readback", cpu_bus.rdata, 32'h1234);
    set_cpu(0, 0, 0, '0);

    // dma burst under lock, then alternation once lock drops
    set_dma(1, 0, 5, '0); dma_lock = 1;
    step("t3pre");
    set_cpu(1, 0, 4, '0);
    for (int i = 0; i < 7; i++) begin
      dma_lock = (i < 5);
      step("t3");
      check($sformatf("t3_pat%0d", i), 32'(got_dma_gnt ? 2 : got_cpu_gnt ? 1 : 0), 32'(pat[i]));
    end
    set_cpu(0, 0, 0, '0); set_dma(0, 0, 0, '0); dma_lock = 0;

    // Out-of-range write then read
    set_cpu(1, 1, 9, 32'hBAD0_0009);
    step("t4");
    check("t4_mem_we", 32'(got_mem_we), 32'h0);
    check("t4_err", 32'(addr_err), 32'h1);
    check("t4_rvalid", 32'(cpu_bus.rvalid), 32'h0);
    set_cpu(0, 0, 0, '0);
    step("t4idle");
    check("t4_err_drop", 32'(addr_err), 32'h0);
    set_cpu(1, 0, 9, '0);
    step("t5");
    check("t5_rvalid", 32'(cpu_bus.rvalid), 32'h1);
    check("t5_rdata", cpu_bus.rdata, 32'h0);
    check("t5_err", 32'(addr_err), 32'h1);
    set_cpu(0, 0, 0, '0);

    // Reset during a dma write to word 0
    set_dma(1, 1, 0, 32'hCAFE_F00D);
    reset = 1;
    step("t6");
    check("t6_mem0", mem_array[0], init_word(0));
    check("t6_rv", 32'({cpu_bus.rvalid, dma_bus.rvalid}), 32'h0);
    reset = 0;
    set_cpu(1, 0, 6, '0); set_dma(1, 0, 7, '0);
    step("t6tie");
    check("t6_tie_cpu", 32'(got_cpu_gnt), 32'h1);
    step("t6tie2");
    set_cpu(0, 0, 0, '0); set_dma(0, 0, 0, '0);

    // Random traffic honouring the hold-until-granted rule
    for (int i = 0; i < 400; i++) begin
      if (!cpu_bus.req || m_prev == 1)
        set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 11), $urandom);
      if (!dma_bus.req || m_prev == 2)
        set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 11), $urandom);
      dma_lock = $urandom_range(0, 3) != 0;
      reset = ($urandom_range(0, 49) == 0);
      step("rnd");
    end
    reset = 0;
    for (int i = 0; i < DEPTH; i++) check($sformatf("final_mem%0d", i), mem_array[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipeline MEM stage (cpu port);
  - a loader/debug DMA port (dma port), which fills or inspects memory at run time.
- Grants one access per cycle, drives the memory's address/write-data/write-enable, and returns registered read data to the winner one cycle later.
- A denied cpu request is reported on cpu_gnt; the hazard unit stalls the pipeline on it.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width (word address, as the memory indexes words).
- DEPTH, 8, number of implemented memory words; addresses >= DEPTH are out of range.
- BURST_MAX, 4, maximum consecutive dma grants while a cpu request is pending.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage requests an access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  combinational; cpu access is performed this cycle.
- cpu_rvalid  out  1  registered; cpu read data is valid.
- cpu_rdata  out  DATA_W  registered read data.
- dma_req, dma_we, dma_addr, dma_wdata  in  same as the cpu_* inputs  dma request signals.
- dma_lock  in  1  dma requests back-to-back grants (burst).
- dma_gnt, dma_rvalid, dma_rdata  out  same as the cpu_* outputs  dma response signals.
- mem_addr  out  ADDR_W  address to the data memory.
- mem_wd  out  DATA_W  write data to the data memory.
- mem_we  out  1  write enable to the data memory.
- mem_rd  in  DATA_W  combinational read data from the data memory.
- addr_err  out  1  registered; one-cycle pulse when a granted access was out of range.

Behaviour:
- Reset (clk edge with reset=1):
  - cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0, addr_err=0.
  - state=IDLE, last_winner=DMA (so cpu wins the first tie), burst_cnt=0.
  - Reset overrides any access in that cycle: no write is committed and no rvalid follows.
- State machine (state = winner of the previous cycle):
  - IDLE: no grant last cycle.
  - CPU_ACC: cpu was granted last cycle.
  - DMA_ACC: dma was granted last cycle.
  - Next state = the winner this cycle, or IDLE if no request.
- Arbitration, combinational, evaluated every cycle outside reset:
  - Only one requester active: it wins.
  - Both active, state=DMA_ACC, dma_lock=1 and burst_cnt<BURST_MAX: dma wins.
  - Otherwise both active: round-robin; the one that is not last_winner wins.
  - At most one of cpu_gnt/dma_gnt is high. Both are 0 during reset.
- burst_cnt:
  - Increments on each dma grant made while cpu_req=1.
  - Clears on any cpu grant and whenever cpu_req=0.
  - Saturates at BURST_MAX.
- Memory drive:
  - mem_addr/mem_wd come from the winner; with no winner they hold the cpu inputs.
  - mem_we = winner_we AND (winner_addr < DEPTH) AND not reset.
  - Out-of-range writes are suppressed.
- Read return, latency 1:
  - At the posedge after a granted read, the winner's rvalid=1 for exactly one cycle.
  - rdata = mem_rd sampled at that edge, or 0 if the address was out of range.
  - A granted write produces no rvalid.
  - rdata holds its value when rvalid=0.
- addr_err: pulses 1 cycle after any granted access (read or write) with addr >= DEPTH.
- Requester obligations:
  - A requester whose gnt=0 keeps req and its address/data stable until it is granted.
  - The arbiter keeps no request queue.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, CPU_ACC=2'd1, DMA_ACC=2'd2;
  - requester ID constants: REQ_CPU=1'b0, REQ_DMA=1'b1;
  - DATA_W/ADDR_W defaults.
- One sub-module, rr_pick2: the two-input round-robin/lock decision. Inputs: req pair, last_winner, lock_ok. Output: grant pair.
- The read-return registers and burst counter stay in the top module.

Test Plan:
- Reset, then a single cpu read of addr 3 with mem word 3=0x0000_00AA:
  - cpu_gnt=1 in the same cycle;
  - next cycle cpu_rvalid=1 and cpu_rdata=0xAA;
  - dma outputs stay 0.
- Simultaneous cpu read (addr 1) and dma write (addr 2, 0x1234), dma_lock=0, held for two cycles:
  - cycle 0: cpu granted (first tie after reset);
  - cycle 1: dma granted;
  - a cpu read of addr 2 in cycle 2 returns 0x1234.
- dma_lock=1 with both requesting continuously, BURST_MAX=4, and dma already winning:
  - dma_gnt high for 4 consecutive cycles;
  - cpu_gnt=1 on the 5th cycle;
  - then alternation resumes.
- cpu write to addr 9 (DEPTH=8):
  - mem_we=0;
  - addr_err=1 for exactly one cycle after;
  - no cpu_rvalid.
- cpu read of addr 9:
  - cpu_rvalid=1 with cpu_rdata=0;
  - addr_err=1 in the same cycle.
- reset asserted while a dma write to addr 0 is granted:
  - memory word 0 is unchanged;
  - all rvalid=0;
  - the first tie after reset goes to cpu.
